// File: rtl/guess_scorer.sv
// -----------------------------------------------------------------------------
// guess_scorer
//
// Sequential Mastermind scoring engine. On an accepted start it latches the
// secret code and the committed guess. It then spends one cycle on exact
// matches and one cycle per guess position on partial matches. Each partial
// match consumes the lowest-index unused code position with the same colour.
// The result is published as counts and as four 2-bit peg codes
// (2 = exact, 1 = partial, 0 = none). The block also tracks the turn count and
// the sticky win/lose game-over state.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             pulse: score the current guess (ignored while busy,
//                     while game_over=1, or together with new_game)
//   new_game          pulse: abort any scoring and clear results and turns
//   code0..code3      secret code colours, positions 0..3 (3 bits each)
//   guess0..guess3    committed guess colours, positions 0..3 (3 bits each)
//   busy              high in every state except IDLE
//   done              one-cycle pulse when a new result is valid
//   exact, partial    match counts 0..4
//   peg0..peg3        peg codes
//   turn_count        guesses scored this game, saturating at MAX_TURNS
//   game_over, win    sticky end-of-game flag; win=1 means the code was found
// -----------------------------------------------------------------------------
module guess_scorer #(
    parameter int MAX_TURNS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       new_game,
    input  logic [2:0] code0,
    input  logic [2:0] code1,
    input  logic [2:0] code2,
    input  logic [2:0] code3,
    input  logic [2:0] guess0,
    input  logic [2:0] guess1,
    input  logic [2:0] guess2,
    input  logic [2:0] guess3,
    output logic       busy,
    output logic       done,
    output logic [2:0] exact,
    output logic [2:0] partial,
    output logic [1:0] peg0,
    output logic [1:0] peg1,
    output logic [1:0] peg2,
    output logic [1:0] peg3,
    output logic [3:0] turn_count,
    output logic       game_over,
    output logic       win
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXACT = 3'd1;
    localparam logic [2:0] S_P0    = 3'd2;
    localparam logic [2:0] S_P1    = 3'd3;
    localparam logic [2:0] S_P2    = 3'd4;
    localparam logic [2:0] S_P3    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [3:0] TURN_LIMIT = 4'(MAX_TURNS);

    // Control and scoring datapath
    logic [2:0]      state_q,   state_d;
    logic [3:0][2:0] code_q,    code_d;
    logic [3:0][2:0] guess_q,   guess_d;
    logic [3:0]      xm_q,      xm_d;      // exact match per position
    logic [3:0]      used_q,    used_d;    // code position already consumed
    logic [2:0]      ex_cnt_q,  ex_cnt_d;  // working counts
    logic [2:0]      pa_cnt_q,  pa_cnt_d;

    // Published results
    logic [2:0]      exact_q,   exact_d;
    logic [2:0]      partial_q, partial_d;
    logic [3:0][1:0] pegs_q,    pegs_d;
    logic [3:0]      turn_q,    turn_d;
    logic            over_q,    over_d;
    logic            win_q,     win_d;
    logic            done_q,    done_d;

    // Partial-match search helpers
    logic [1:0]      k_pos;     // guess position examined in the current Pk
    logic            pm_found;
    logic [1:0]      pm_sel;
    logic [3:0]      turn_inc;
    logic [3:0]      peg_span;

    always_comb begin
        case (state_q)
            S_P1:    k_pos = 2'd1;
            S_P2:    k_pos = 2'd2;
            S_P3:    k_pos = 2'd3;
            default: k_pos = 2'd0;
        endcase
    end

    // Lowest unused code position whose colour equals guess[k_pos]. Scanning
    // downward lets the lowest index overwrite any higher hit.
    always_comb begin
        pm_found = 1'b0;
        pm_sel   = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (!used_q[j] && (code_q[j] == guess_q[k_pos])) begin
                pm_found = 1'b1;
                pm_sel   = 2'(j);
            end
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        code_d    = code_q;
        guess_d   = guess_q;
        xm_d      = xm_q;
        used_d    = used_q;
        ex_cnt_d  = ex_cnt_q;
        pa_cnt_d  = pa_cnt_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        pegs_d    = pegs_q;
        turn_d    = turn_q;
        over_d    = over_q;
        win_d     = win_q;
        done_d    = 1'b0;
        turn_inc  = (turn_q < TURN_LIMIT) ? turn_q + 4'd1 : turn_q;
        peg_span  = {1'b0, ex_cnt_q} + {1'b0, pa_cnt_q};

        case (state_q)
            S_IDLE: begin
                if (start && !over_q && !new_game) begin
                    code_d  = {code3, code2, code1, code0};
                    guess_d = {guess3, guess2, guess1, guess0};
                    state_d = S_EXACT;
                end
            end

            S_EXACT: begin
                for (int i = 0; i < 4; i++) begin
                    xm_d[i] = (code_q[i] == guess_q[i]);
                end
                used_d   = xm_d;
                ex_cnt_d = {2'b00, xm_d[0]} + {2'b00, xm_d[1]}
                         + {2'b00, xm_d[2]} + {2'b00, xm_d[3]};
                pa_cnt_d = 3'd0;
                state_d  = S_P0;
            end

            S_P0, S_P1, S_P2, S_P3: begin
                // A guess position that matched exactly is never a partial.
                if (!xm_q[k_pos] && pm_found) begin
                    pa_cnt_d       = pa_cnt_q + 3'd1;
                    used_d[pm_sel] = 1'b1;
                end
                state_d = (state_q == S_P3) ? S_DONE : state_q + 3'd1;
            end

            S_DONE: begin
                // Exact pegs first, then partial pegs, then blanks.
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) < ex_cnt_q) begin
                        pegs_d[i] = 2'd2;
                    end else if (4'(i) < peg_span) begin
                        pegs_d[i] = 2'd1;
                    end else begin
                        pegs_d[i] = 2'd0;
                    end
                end
                exact_d   = ex_cnt_q;
                partial_d = pa_cnt_q;
                turn_d    = turn_inc;
                win_d     = (ex_cnt_q == 3'd4);
                over_d    = (ex_cnt_q == 3'd4) || (turn_inc == TURN_LIMIT);
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // new_game overrides everything, including a start in the same cycle
        // and a scoring run that would otherwise finish on this edge.
        if (new_game) begin
            state_d   = S_IDLE;
            exact_d   = 3'd0;
            partial_d = 3'd0;
            pegs_d    = '0;
            turn_d    = 4'd0;
            over_d    = 1'b0;
            win_d     = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            // NOTE: the latched operands are reset too, even though they are
            // always rewritten before use; this keeps simulation X-free and
            // costs nothing at this size.
            code_q    <= '0;
            guess_q   <= '0;
            xm_q      <= '0;
            used_q    <= '0;
            ex_cnt_q  <= '0;
            pa_cnt_q  <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            pegs_q    <= '0;
            turn_q    <= '0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q   <= state_d;
            code_q    <= code_d;
            guess_q   <= guess_d;
            xm_q      <= xm_d;
            used_q    <= used_d;
            ex_cnt_q  <= ex_cnt_d;
            pa_cnt_q  <= pa_cnt_d;
            exact_q   <= exact_d;
            partial_q <= partial_d;
            pegs_q    <= pegs_d;
            turn_q    <= turn_d;
            over_q    <= over_d;
            win_q     <= win_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign exact      = exact_q;
    assign partial    = partial_q;
    assign peg0       = pegs_q[0];
    assign peg1       = pegs_q[1];
    assign peg2       = pegs_q[2];
    assign peg3       = pegs_q[3];
    assign turn_count = turn_q;
    assign game_over  = over_q;
    assign win        = win_q;

endmodule

// File: doc/guess_scorer.md
# guess_scorer

Sequential Mastermind scoring engine. It answers each guess that the history block commits: it latches the secret code and the committed guess, then counts exact (right colour, right position) and partial (right colour, wrong position) matches with standard duplicate handling. It packs the result into four 2-bit peg codes for the seven-segment converters. It also tracks the turn count and the win/lose game-over condition.

## Interface
Parameters:
- MAX_TURNS, 8, number of scored guesses allowed before the game is lost (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse: score the current guess
- new_game  in  1  one-cycle pulse: clear score, turn count and game-over
- code0..code3  in  3 each  secret code colours, positions 0..3
- guess0..guess3  in  3 each  committed guess colours, positions 0..3
- busy  out  1  high while scoring is in progress
- done  out  1  one-cycle pulse when a new result is valid
- exact  out  3  exact-match count, 0..4
- partial  out  3  partial-match count, 0..4
- peg0..peg3  out  2 each  peg codes: 2'd2 exact, 2'd1 partial, 2'd0 none
- turn_count  out  4  guesses scored this game
- game_over  out  1  sticky; set on a win or when the turn limit is reached
- win  out  1  valid while game_over=1; 1 means the code was found

## Operation
- Colours are 3-bit and all 8 values are legal.
- FSM states: IDLE, EXACT, P0, P1, P2, P3, DONE.
- **IDLE**
  - On start=1 with game_over=0 and new_game=0: latch code0..3 and guess0..3 into internal registers, then go to EXACT.
  - Otherwise stay in IDLE.
- **EXACT**
  - For each position i, set xm[i] = (code[i]==guess[i]).
  - Set code_used[i] = xm[i].
  - Set exact count = popcount(xm).
  - Go to P0.
- **Pk (k = 0..3)**
  - If xm[k]=0, find the lowest j with code_used[j]=0 and code[j]==guess[k].
  - If such a j exists, increment the partial count and set code_used[j]=1.
  - Go to the next Pk; P3 goes to DONE.
- **DONE**
  - Drive the registered outputs:
    - peg0..peg(exact-1) = 2'd2
    - the next `partial` pegs = 2'd1
    - the remaining pegs = 2'd0
  - Increment turn_count, saturating at MAX_TURNS.
  - If exact==4: game_over=1, win=1.
  - Else if the new turn_count==MAX_TURNS: game_over=1, win=0.
  - Return to IDLE.
- busy=1 in every state except IDLE.
- exact, partial, peg0..3 and win hold their values until the next DONE, new_game or rst.
- **Ignored and overriding events**
  - start while busy=1 is ignored; it is not queued.
  - start while game_over=1 is ignored.
  - Input code/guess changes after the latch edge do not affect the result in progress.
- **new_game**
  - In IDLE: clears exact, partial, pegs, turn_count, game_over and win on the next edge.
  - While busy: aborts to IDLE with the same clearing; no done pulse.
  - new_game together with start: new_game wins and start is ignored.
- **rst** at any time, including mid-scoring: next edge gives state IDLE and every output 0.

## Timing
- Reset value of every output is 0: busy, done, exact, partial, peg0..3, turn_count, game_over, win.
- Edge E0 samples start=1 and latches the inputs.
- busy rises after E0.
- E1 = EXACT, E2..E5 = P0..P3.
- E6 is the DONE edge:
  - done=1 for exactly one cycle after E6.
  - exact, partial, pegs, turn_count, game_over and win update on E6.
  - busy falls after E6.
- Latency from start edge to done is 6 clocks.
- Throughput: the earliest next accepted start is the edge that follows E6.

## Test plan
- Win: code 1,2,3,4 and guess 1,2,3,4, start at E0.
  - done only after E6.
  - exact=4, partial=0, pegs 2,2,2,2.
  - game_over=1, win=1, turn_count=1.
  - A further start is ignored.
- All partial: code 1,1,2,2 and guess 2,2,1,1.
  - exact=0, partial=4, pegs 1,1,1,1, game_over=0.
- Duplicate guess colour: code 1,2,3,4 and guess 1,1,1,1.
  - exact=1, partial=0, pegs 2,0,0,0.
- Lowest-index consumption: code 5,0,0,0 and guess 0,5,6,7.
  - exact=0, partial=2, pegs 1,1,0,0.
  - A start pulsed at E3 of the same scoring is ignored: a single done.
- Turn limit, MAX_TURNS=8: eight non-winning guesses.
  - After the 8th done: turn_count=8, game_over=1, win=0.
  - A 9th start produces no done.
  - new_game clears turn_count to 0 and game_over to 0.
- Reset and abort:
  - rst asserted in state P1: next cycle busy=0, all outputs 0, no done.
  - new_game and start pulsed in the same cycle: no scoring occurs and busy stays 0.
